// File: rtl/neopixel_frame_sequencer.sv
// -----------------------------------------------------------------------------
// neopixel_frame_sequencer
//
// Double-buffered frame sequencer for a NeoPixel strand controller. The host
// writes pixel colours into a staging buffer; a commit pulse copies the staged
// frame into the active buffer in one cycle. The active frame is then streamed
// to the strand controller one colour byte at a time (R, B, G per pixel, pixel
// 0 first), followed by a send request. An optional refresh timer resends the
// active frame periodically.
//
// Ports
//   clock, reset_L        : clock and asynchronous active-low reset
//   wr_valid/wr_ready     : host pixel write handshake
//   wr_pixel, wr_grb      : pixel index and colour {G,R,B}
//   commit                : one-cycle request to display the staged frame
//   auto_refresh_en       : enable periodic resend of the active frame
//   busy, frame_done      : status (not idle / transmission complete pulse)
//   color_level/_index,
//   pixel_index,
//   load_color, send_it   : strand-side load and send requests
//   ready_to_load/_send   : strand-side flow control
// -----------------------------------------------------------------------------
module neopixel_frame_sequencer #(
    parameter int NUM_PIXELS     = 5,
    parameter int REFRESH_CYCLES = 500000
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_pixel,
    input  logic [23:0] wr_grb,
    input  logic        commit,
    input  logic        auto_refresh_en,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  color_level,
    output logic [1:0]  color_index,
    output logic [2:0]  pixel_index,
    output logic        load_color,
    output logic        send_it,
    input  logic        ready_to_load,
    input  logic        ready_to_send
);

    localparam int TW = $clog2(REFRESH_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_CYCLES - 1);
    localparam logic [2:0]    LAST_PIXEL = 3'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        COPY,
        LOAD,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      pix_reg, pix_next;
    logic [1:0]      col_reg, col_next;
    logic            pend_reg;
    logic            due_reg;
    logic [TW-1:0]   timer_reg;
    logic            load_start;
    logic            wr_accept;
    logic [23:0]     active_px;
    logic [23:0]     active_arr [NUM_PIXELS];

    assign wr_ready  = (state_reg != COPY);
    assign wr_accept = wr_valid && wr_ready;
    assign busy      = (state_reg != IDLE);

    // Per-pixel staging/active registers. Writes to indices beyond the strand
    // match no pixel and are silently dropped. The COPY cycle blocks writes,
    // so the copy always sees a stable staging buffer.
    generate
        for (genvar gi = 0; gi < NUM_PIXELS; gi++) begin : g_pixel
            logic [23:0] staging_reg;
            logic [23:0] active_reg;

            always_ff @(posedge clock or negedge reset_L) begin
                if (!reset_L) begin
                    staging_reg <= '0;
                    active_reg  <= '0;
                end else begin
                    if (wr_accept && (wr_pixel == 3'(gi)))
                        staging_reg <= wr_grb;
                    if (state_reg == COPY)
                        active_reg <= staging_reg;
                end
            end

            assign active_arr[gi] = active_reg;
        end
    endgenerate

    // Select the active pixel addressed by the load counter.
    always_comb begin
        active_px = '0;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            if (pix_reg == 3'(i))
                active_px = active_arr[i];
        end
    end

    // Next-state and strand-side outputs. Outputs are Mealy on the ready
    // inputs so a pulse is issued in the very cycle the strand is ready.
    always_comb begin
        state_next  = state_reg;
        pix_next    = pix_reg;
        col_next    = col_reg;
        load_color  = 1'b0;
        send_it     = 1'b0;
        frame_done  = 1'b0;
        color_level = '0;
        color_index = '0;
        pixel_index = '0;

        case (state_reg)
            IDLE: begin
                if (pend_reg)
                    state_next = COPY;
                else if (due_reg)
                    state_next = LOAD;
            end
            COPY: state_next = LOAD;
            LOAD: begin
                if (ready_to_load) begin
                    load_color  = 1'b1;
                    pixel_index = pix_reg;
                    color_index = col_reg;
                    case (col_reg)
                        2'd0:    color_level = active_px[15:8];
                        2'd1:    color_level = active_px[7:0];
                        default: color_level = active_px[23:16];
                    endcase
                    if (col_reg == 2'd2) begin
                        col_next = 2'd0;
                        if (pix_reg == LAST_PIXEL)
                            state_next = SEND;
                        else
                            pix_next = pix_reg + 3'd1;
                    end else begin
                        col_next = col_reg + 2'd1;
                    end
                end
            end
            SEND: begin
                if (ready_to_send) begin
                    send_it    = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!ready_to_send)
                    state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (ready_to_send) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Every entry into LOAD starts the frame from (pixel 0, R).
        load_start = (state_reg != LOAD) && (state_next == LOAD);
        if (load_start) begin
            pix_next = '0;
            col_next = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_reg <= IDLE;
            pix_reg   <= '0;
            col_reg   <= '0;
            pend_reg  <= 1'b0;
            due_reg   <= 1'b0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            pix_reg   <= pix_next;
            col_reg   <= col_next;

            // A commit landing in the COPY cycle is kept for the next frame.
            if (state_reg == COPY)
                pend_reg <= 1'b0;
            if (commit)
                pend_reg <= 1'b1;

            if (!auto_refresh_en) begin
                timer_reg <= '0;
                due_reg   <= 1'b0;
            end else begin
                if (load_start)
                    due_reg <= 1'b0;
                if (frame_done) begin
                    timer_reg <= '0;
                end else if (timer_reg == TIMER_LAST) begin
                    timer_reg <= '0;
                    due_reg   <= 1'b1;
                end else begin
                    timer_reg <= timer_reg + TW'(1);
                end
            end
        end
    end

endmodule

// File: doc/neopixel_frame_sequencer.md
NEOPIXEL_FRAME_SEQUENCER -- requirements
Module: neopixel_frame_sequencer

Interface
REQ-001 Parameter NUM_PIXELS, default 5: number of pixels on the strand, legal range 1-8.
REQ-002 Parameter REFRESH_CYCLES, default 500000: auto-refresh period in clock cycles (10 ms at 50 MHz), minimum 2.
REQ-003 Port `clock`, input, 1 bit: the single clock (50 MHz); all state SHALL change on its rising edge.
REQ-004 Port `reset_L`, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port `wr_valid`, input, 1 bit: host pixel write request.
REQ-006 Port `wr_ready`, output, 1 bit: the write is accepted in any cycle where `wr_valid` and `wr_ready` are both 1.
REQ-007 Port `wr_pixel`, input, 3 bits: index of the pixel to write.
REQ-008 Port `wr_grb`, input, 24 bits: pixel colour as {G[23:16], R[15:8], B[7:0]}.
REQ-009 Port `commit`, input, 1 bit: a single-cycle pulse that requests display of the staged frame.
REQ-010 Port `auto_refresh_en`, input, 1 bit: enables periodic resend of the active frame.
REQ-011 Port `busy`, output, 1 bit: high whenever the state is not IDLE.
REQ-012 Port `frame_done`, output, 1 bit: a one-cycle pulse when a frame transmission completes.
REQ-013 Strand-side outputs: `color_level` (8 bits), `color_index` (2 bits), `pixel_index` (3 bits), `load_color` (1 bit), `send_it` (1 bit).
REQ-014 Strand-side inputs: `ready_to_load` (1 bit) and `ready_to_send` (1 bit), driven by the strand controller.

Function
REQ-015 The block SHALL hold two NUM_PIXELS x 24-bit buffers: a staging buffer and an active buffer.
REQ-016 An accepted write SHALL store `wr_grb` into staging[`wr_pixel`]; a write with `wr_pixel` >= NUM_PIXELS SHALL be accepted and discarded.
REQ-017 `wr_ready` SHALL be 1 in every cycle except the COPY cycle.
REQ-018 A `commit` pulse SHALL set `pend_commit`, which stays set until the next COPY, in any state.
REQ-019 A write accepted in the same cycle as `commit` SHALL be part of the committed frame.
REQ-020 Refresh timer behaviour:
- counts only while `auto_refresh_en`=1; held at 0 and `refresh_due` cleared while `auto_refresh_en`=0;
- on reaching REFRESH_CYCLES-1, sets `refresh_due` and wraps to 0;
- restarts at 0 on `frame_done`.
REQ-021 The state machine SHALL have the states IDLE, COPY, LOAD, SEND, WAIT_ACK and WAIT_DONE.
REQ-022 IDLE SHALL go to COPY if `pend_commit`=1; otherwise to LOAD if `refresh_due`=1; otherwise stay in IDLE. If both are set, commit wins.
REQ-023 COPY SHALL last exactly one cycle: it copies the staging buffer to the active buffer, clears `pend_commit` and goes to LOAD.
REQ-024 Entering LOAD SHALL clear `refresh_due` and zero the load counter (pixel p, colour c).
REQ-025 Load order SHALL be p = 0..NUM_PIXELS-1; within each pixel, c = R(00), B(01), G(10).
REQ-026 In LOAD, whenever `ready_to_load`=1, the block SHALL assert `load_color`=1 for that cycle, with:
- `pixel_index` = p;
- `color_index` = c;
- `color_level` = the matching byte of active[p];
- then advance the counter.
REQ-027 In LOAD, whenever `ready_to_load`=0, `load_color` SHALL be 0 and the counter SHALL hold.
REQ-028 After the pulse for (NUM_PIXELS-1, G) the block SHALL go to SEND; LOAD therefore issues exactly 3*NUM_PIXELS pulses.
REQ-029 In SEND, `send_it` SHALL be 1 in the first cycle where `ready_to_send`=1, and the block then goes to WAIT_ACK.
REQ-030 WAIT_ACK SHALL wait for `ready_to_send`=0 and then go to WAIT_DONE.
REQ-031 WAIT_DONE SHALL wait for `ready_to_send`=1, then pulse `frame_done` for one cycle and go to IDLE.
REQ-032 `load_color` and `send_it` SHALL never both be 1 in the same cycle; `load_color` SHALL never be 1 outside LOAD.
REQ-033 A `commit` that arrives while `busy`=1 SHALL NOT disturb the frame in flight; it is serviced at the next IDLE.
REQ-034 Strand-side data outputs SHALL be 0 whenever `load_color`=0.

Reset
REQ-035 While `reset_L`=0, regardless of state:
- state = IDLE, `pend_commit` = 0, `refresh_due` = 0, refresh timer = 0, load counter = 0;
- both buffers cleared to zero.
REQ-036 While `reset_L`=0, outputs SHALL be `busy`=0, `frame_done`=0, `load_color`=0, `send_it`=0, strand-side data outputs = 0 and `wr_ready`=1.
REQ-037 An assertion of `reset_L` in the middle of a frame SHALL abandon that frame immediately, with no further `load_color` or `send_it` pulses.

Verification
REQ-038 Write pixels 0-4 = 0x112233..0x556677, then commit, with ready lines held at 1 -> exactly 15 `load_color` pulses: (0,R,0x22), (0,B,0x33), (0,G,0x11) ... (4,G,0x55), then one `send_it`.
REQ-039 Hold `ready_to_load`=0 for 10 cycles during LOAD -> no pulses and the counter holds; the sequence resumes at the same (p,c).
REQ-040 Commit during WAIT_DONE -> the current frame completes with `frame_done`; then COPY and a second frame carrying the new data.
REQ-041 `auto_refresh_en`=1, REFRESH_CYCLES=100, with no commit -> a frame starts every 100 cycles after `frame_done`, resending the unchanged active buffer.
REQ-042 Write to `wr_pixel`=6, then commit -> the staging buffer is unchanged and the transmitted frame is identical to the previous one.
REQ-043 Drive `reset_L`=0 after the 7th `load_color` pulse -> all outputs go to their reset values and the buffers are zero; a following commit sends all-zero colours.
